// File: rtl/image_stream_loader.sv
// image_stream_loader
//
// Receives a serial pixel stream over a valid/ready handshake and assembles
// one complete image vector for the convolution layer. When the last slot of
// a frame has been written, conv_ena pulses for one cycle and the image is held
// until the layer returns conv_done. The stream then reopens for the next frame.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous reset, active low (0 = reset)
//   pix_in     pixel word; stored as is, with no arithmetic
//   pix_valid  pix_in is valid
//   pix_last   source marks the final pixel of a frame
//   pix_ready  loader accepts a pixel this cycle (decoded from state)
//   image      assembled frame; pixel k is stored at image[k*DATA_WIDTH +: DATA_WIDTH]
//   conv_ena   one-cycle start pulse to the convolution layer
//   conv_done  the convolution layer has finished with the current image
//   frame_err  one-cycle pulse when pix_last does not line up with the frame end
//
// state   | meaning
// --------+------------------------------------------------------------
// S_LOAD  | stream open, accepting pixels into slot idx
// S_START | frame complete, conv_ena high for this single cycle
// S_WAIT  | image held stable, waiting for conv_done

module image_stream_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int D          = 1,
    parameter int H          = 32,
    parameter int W          = 32
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [DATA_WIDTH-1:0]            pix_in,
    input  logic                             pix_valid,
    input  logic                             pix_last,
    output logic                             pix_ready,
    output logic [0:D*H*W*DATA_WIDTH-1]      image,
    output logic                             conv_ena,
    input  logic                             conv_done,
    output logic                             frame_err
);

    localparam int N     = D * H * W;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        S_LOAD,
        S_START,
        S_WAIT
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] idx;
    logic             accept;
    logic             last_slot;
    logic             err_nxt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // pix_ready and conv_ena depend only on the state register, so there is
    // no combinational path from pix_valid to pix_ready.
    always_comb begin
        state_nxt = state;
        pix_ready = 1'b0;
        conv_ena  = 1'b0;
        accept    = 1'b0;
        err_nxt   = 1'b0;
        last_slot = (idx == IDX_LAST);
        case (state)
            S_LOAD: begin
                pix_ready = 1'b1;
                accept    = pix_valid;
                if (pix_valid) begin
                    if (last_slot) begin
                        // The frame is full: it is delivered even when the
                        // source did not mark the end.
                        state_nxt = S_START;
                        err_nxt   = ~pix_last;
                    end else begin
                        // An early end abandons the partial frame.
                        err_nxt = pix_last;
                    end
                end
            end
            S_START: begin
                conv_ena  = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (conv_done) begin
                    state_nxt = S_LOAD;
                end
            end
            default: begin
                state_nxt = S_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            idx       <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= err_nxt;
            if (accept) begin
                if (last_slot || pix_last) begin
                    idx <= '0;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

    // Each slot is written through a decode of idx, so every slice select is
    // a constant and the storage maps to one enable per slot.
    always_ff @(posedge clk) begin
        if (!reset) begin
            image <= '0;
        end else if (accept) begin
            for (int k = 0; k < N; k++) begin
                if (idx == IDX_W'(k)) begin
                    image[k*DATA_WIDTH +: DATA_WIDTH] <= pix_in;
                end
            end
        end
    end

endmodule

// File: tb/tb_image_stream_loader.sv
module tb_image_stream_loader;

    localparam int DW = 8;
    localparam int D  = 1;
    localparam int H  = 4;
    localparam int W  = 4;
    localparam int N  = D * H * W;
    localparam int IW = N * DW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] pix_in = '0;
    logic          pix_valid = 1'b0;
    logic          pix_last = 1'b0;
    logic          conv_done = 1'b0;
    logic          pix_ready;
    logic          conv_ena;
    logic          frame_err;
    logic [0:IW-1] image;

    always #5 clk = ~clk;

    image_stream_loader #(
        .DATA_WIDTH(DW),
        .D(D),
        .H(H),
        .W(W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .pix_in(pix_in),
        .pix_valid(pix_valid),
        .pix_last(pix_last),
        .pix_ready(pix_ready),
        .image(image),
        .conv_ena(conv_ena),
        .conv_done(conv_done),
        .frame_err(frame_err)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference frame contents and write position, advanced only by beats the
    // bench knows are offered while the stream is open.
    logic [DW-1:0] m_img [N];
    int            m_idx = 0;

    typedef struct {
        logic          ena;
        logic          err;
        logic [IW-1:0] img;
    } ev_t;

    ev_t exp_q[$];

    // Slot 0 is the leftmost byte of the numeric view.
    function automatic logic [IW-1:0] pack_model();
        logic [IW-1:0] v;
        v = '0;
        for (int k = 0; k < N; k++) v[IW-1-k*DW -: DW] = m_img[k];
        return v;
    endfunction

    task automatic check(input string name, input logic [IW-1:0] act, input logic [IW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic clear_model();
        for (int k = 0; k < N; k++) m_img[k] = '0;
        m_idx = 0;
    endtask

    task automatic beat(input logic [DW-1:0] d, input logic last);
        ev_t e;
        pix_in    = d;
        pix_last  = last;
        pix_valid = 1'b1;
        m_img[m_idx] = d;
        if (m_idx == N - 1) begin
            e.ena = 1'b1;
            e.err = ~last;
            e.img = pack_model();
            exp_q.push_back(e);
            m_idx = 0;
        end else if (last) begin
            e.ena = 1'b0;
            e.err = 1'b1;
            e.img = '0;
            exp_q.push_back(e);
            m_idx = 0;
        end else begin
            m_idx++;
        end
        step();
        pix_valid = 1'b0;
        pix_last  = 1'b0;
    endtask

    task automatic frame(input logic [DW-1:0] base, input logic last_ok);
        for (int i = 0; i < N; i++) beat(base + DW'(i), (i == N - 1) && last_ok);
    endtask

    // Called during the START cycle; returns in the first reopened LOAD cycle.
    task automatic release_wait();
        step();
        conv_done = 1'b1;
        step();
        conv_done = 1'b0;
        check("reopen_ready", pix_ready, 1);
    endtask

    // Every conv_ena or frame_err cycle must match the next queued expectation.
    always @(negedge clk) begin
        if (conv_ena === 1'b1 || frame_err === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_event: conv_ena=%b frame_err=%b, want no event", conv_ena, frame_err);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                check("ev_conv_ena", conv_ena, e.ena);
                check("ev_frame_err", frame_err, e.err);
                if (e.ena) check("ev_image", image, e.img);
            end
        end
    end

    initial begin
        clear_model();
        reset = 1'b0;
        idle(2);
        reset = 1'b1;
        check("rst_ready", pix_ready, 1);
        check("rst_image", image, 0);
        check("rst_conv_ena", conv_ena, 0);
        check("rst_frame_err", frame_err, 0);

        // Full frame 0x01..0x10, then pixels offered while waiting.
        frame(8'h01, 1'b1);
        check("t1_start_ena", conv_ena, 1);
        check("t1_start_ready", pix_ready, 0);
        check("t1_image_value", image, 128'h0102030405060708090a0b0c0d0e0f10);
        step();
        check("t1_wait_ena", conv_ena, 0);
        check("t1_wait_ready", pix_ready, 0);
        pix_valid = 1'b1;
        pix_in    = 8'hee;
        pix_last  = 1'b1;
        idle(3);
        check("t1_wait_ready_held", pix_ready, 0);
        check("t1_image_stable", image, pack_model());
        conv_done = 1'b1;
        step();
        conv_done = 1'b0;
        pix_valid = 1'b0;
        pix_last  = 1'b0;
        check("t1_reopen_ready", pix_ready, 1);

        // Bubbles inside the frame.
        for (int i = 0; i < N; i++) begin
            beat(8'h21 + DW'(i), i == N - 1);
            if (i % 3 == 1) idle(1);
            if (i == 7) idle(2);
        end
        release_wait();
        check("t2_hold_after_reopen", image, pack_model());

        // Early last on beat 5, then a full frame from slot 0.
        for (int i = 0; i < 5; i++) beat(8'ha0 + DW'(i), i == 4);
        check("t3_still_load", pix_ready, 1);
        frame(8'h41, 1'b1);
        release_wait();

        // Missing last: frame delivered with frame_err alongside conv_ena.
        frame(8'h61, 1'b0);
        release_wait();

        // conv_done held high throughout: ignored in LOAD, single WAIT cycle.
        conv_done = 1'b1;
        frame(8'hc1, 1'b1);
        check("t5_start_ena", conv_ena, 1);
        step();
        check("t5_wait_ready", pix_ready, 0);
        check("t5_wait_ena", conv_ena, 0);
        step();
        check("t5_load_ready", pix_ready, 1);
        conv_done = 1'b0;

        // Reset after beat 9, with a beat offered during reset.
        for (int i = 0; i < 9; i++) beat(8'h70 + DW'(i), 1'b0);
        reset     = 1'b0;
        pix_valid = 1'b1;
        pix_in    = 8'hee;
        step();
        reset     = 1'b1;
        pix_valid = 1'b0;
        clear_model();
        check("t6a_image_zero", image, 0);
        check("t6a_ready", pix_ready, 1);
        check("t6a_ena", conv_ena, 0);
        frame(8'h81, 1'b1);
        release_wait();

        // Reset during WAIT.
        frame(8'h91, 1'b1);
        step();
        check("t6b_wait_ready", pix_ready, 0);
        reset = 1'b0;
        step();
        reset = 1'b1;
        clear_model();
        check("t6b_image_zero", image, 0);
        check("t6b_ready", pix_ready, 1);
        check("t6b_ena", conv_ena, 0);
        frame(8'hb1, 1'b1);
        release_wait();

        idle(3);
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
